// File: rtl/mem_arbiter.sv
// Main-memory sequencer shared by the I-cache and D-cache: fixed-priority arbitration,
// 8-word pipelined block fills, single-word write-through stores and pipeline stalls.
//
// state  | meaning
// IDLE   | no memory traffic; arbitrate d_wr_req > d_miss > i_miss
// WRITE  | one-cycle store issue with d_wr_ack
// FILL_I | issue block reads and stream returning words into the I-cache
// FILL_D | issue block reads and stream returning words into the D-cache
module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int WORDS   = 8,
  parameter int MEM_LAT = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_miss,
  input  logic [ADDR_W-1:0]         i_miss_addr,
  input  logic                      d_miss,
  input  logic [ADDR_W-1:0]         d_miss_addr,
  input  logic                      d_wr_req,
  input  logic [ADDR_W-1:0]         d_wr_addr,
  input  logic [DATA_W-1:0]         d_wr_data,
  output logic                      mem_en,
  output logic                      mem_wr,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  input  logic                      mem_data_valid,
  output logic [DATA_W-1:0]         fill_data,
  output logic [$clog2(WORDS)-1:0]  fill_idx,
  output logic                      i_fill_we,
  output logic                      d_fill_we,
  output logic                      i_fill_done,
  output logic                      d_fill_done,
  output logic                      d_wr_ack,
  output logic                      i_stall,
  output logic                      d_stall
);

  localparam int IDX_W = $clog2(WORDS);
  localparam int CNT_W = IDX_W + 1;
  localparam int OFF_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] ISSUE_END = CNT_W'(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, WRITE, FILL_I, FILL_D} state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  issue_cnt, issue_d;
  logic [IDX_W-1:0]  recv_cnt, recv_d;
  logic [ADDR_W-1:0] blk, blk_d;
  logic              filling;
  logic              unused_ok;

  // Byte offset within a block is irrelevant once the block base is captured.
  assign unused_ok = ^{i_miss_addr[OFF_W-1:0], d_miss_addr[OFF_W-1:0], (MEM_LAT != 0)};

  assign filling = (state == FILL_I) || (state == FILL_D);
  assign i_stall = i_miss;
  assign d_stall = d_miss | d_wr_req;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      blk       <= '0;
    end else begin
      state     <= state_d;
      issue_cnt <= issue_d;
      recv_cnt  <= recv_d;
      blk       <= blk_d;
    end
  end

  always_comb begin
    state_d     = state;
    issue_d     = issue_cnt;
    recv_d      = recv_cnt;
    blk_d       = blk;
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    fill_data   = '0;
    fill_idx    = '0;
    i_fill_we   = 1'b0;
    d_fill_we   = 1'b0;
    i_fill_done = 1'b0;
    d_fill_done = 1'b0;
    d_wr_ack    = 1'b0;

    case (state)
      IDLE: begin
        if (d_wr_req) begin
          state_d = WRITE;
        end else if (d_miss) begin
          blk_d   = {d_miss_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          state_d = FILL_D;
        end else if (i_miss) begin
          blk_d   = {i_miss_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          state_d = FILL_I;
        end
      end

      WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = d_wr_addr;
        mem_wdata = d_wr_data;
        d_wr_ack  = 1'b1;
        state_d   = IDLE;
      end

      FILL_I, FILL_D: begin
        if (issue_cnt < ISSUE_END) begin
          mem_en   = 1'b1;
          mem_addr = {blk[ADDR_W-1:OFF_W], issue_cnt[IDX_W-1:0], 1'b0};
          issue_d  = issue_cnt + 1'b1;
        end
        // Read data is only accepted while a fill owns the memory; stale
        // returns after an abandoned fill land in IDLE and are dropped.
        if (filling && mem_data_valid) begin
          fill_data = mem_rdata;
          fill_idx  = recv_cnt;
          i_fill_we = (state == FILL_I);
          d_fill_we = (state == FILL_D);
          recv_d    = recv_cnt + 1'b1;
          if (recv_cnt == LAST_IDX) begin
            i_fill_done = (state == FILL_I);
            d_fill_done = (state == FILL_D);
            state_d     = IDLE;
            issue_d     = '0;
            recv_d      = '0;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a 4-cycle pipelined memory model returns addr^0x5A5A,
// and requesters drop their request the cycle after done/ack.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_miss, d_miss, d_wr_req;
  logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, fill_data;
  logic        mem_data_valid;
  logic [2:0]  fill_idx;
  logic        i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_ack, i_stall, d_stall;

  int errors = 0;
  int checks = 0;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .d_miss(d_miss), .d_miss_addr(d_miss_addr),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid),
    .fill_data(fill_data), .fill_idx(fill_idx),
    .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
    .i_fill_done(i_fill_done), .d_fill_done(d_fill_done),
    .d_wr_ack(d_wr_ack), .i_stall(i_stall), .d_stall(d_stall)
  );

  always #5 clk = ~clk;

  // Memory model: a read issued in cycle k returns in cycle k+4.
  logic [3:0]  pv = 4'b0;
  logic [15:0] pa [4];
  always @(posedge clk) begin
    pv    <= {pv[2:0], mem_en & ~mem_wr};
    pa[0] <= mem_addr;
    pa[1] <= pa[0];
    pa[2] <= pa[1];
    pa[3] <= pa[2];
  end
  assign mem_data_valid = pv[3];
  assign mem_rdata      = pv[3] ? (pa[3] ^ 16'h5A5A) : 16'h0000;

  // Observation record, indexed by cycle number since the last clear_obs().
  int          cyc;
  logic [15:0] rd_a[$];
  int          rd_c[$];
  logic [15:0] wr_a[$], wr_d[$];
  int          wr_c[$];
  logic [2:0]  ii_q[$], di_q[$];
  logic [15:0] id_q[$], dd_q[$];
  int          ic_q[$], dc_q[$];
  int          idone_q[$], ddone_q[$], ack_q[$];
  int          istall_n, dstall_n;

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_obs();
    cyc = 0;
    rd_a.delete(); rd_c.delete(); wr_a.delete(); wr_d.delete(); wr_c.delete();
    ii_q.delete(); di_q.delete(); id_q.delete(); dd_q.delete(); ic_q.delete(); dc_q.delete();
    idone_q.delete(); ddone_q.delete(); ack_q.delete();
    istall_n = 0;
    dstall_n = 0;
  endtask

  // Records n cycles of DUT activity and plays the requesters' deassert behaviour.
  task automatic observe(input int n);
    for (int k = 0; k < n; k++) begin
      bit drop_i, drop_d, drop_w;
      #1;
      if (mem_en && !mem_wr) begin rd_a.push_back(mem_addr); rd_c.push_back(cyc); end
      if (mem_en && mem_wr) begin wr_a.push_back(mem_addr); wr_d.push_back(mem_wdata); wr_c.push_back(cyc); end
      if (i_fill_we) begin ii_q.push_back(fill_idx); id_q.push_back(fill_data); ic_q.push_back(cyc); end
      if (d_fill_we) begin di_q.push_back(fill_idx); dd_q.push_back(fill_data); dc_q.push_back(cyc); end
      if (i_fill_done) idone_q.push_back(cyc);
      if (d_fill_done) ddone_q.push_back(cyc);
      if (d_wr_ack) ack_q.push_back(cyc);
      if (i_stall) istall_n++;
      if (d_stall) dstall_n++;
      drop_i = i_fill_done;
      drop_d = d_fill_done;
      drop_w = d_wr_ack;
      nxt();
      cyc++;
      if (drop_i) i_miss = 1'b0;
      if (drop_d) d_miss = 1'b0;
      if (drop_w) d_wr_req = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_miss = 1'b0; d_miss = 1'b0; d_wr_req = 1'b0;
    i_miss_addr = '0; d_miss_addr = '0; d_wr_addr = '0; d_wr_data = '0;
    repeat (2) nxt();
    #1;
    checks++;
    if ({mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_idx, i_fill_we, d_fill_we,
         i_fill_done, d_fill_done, d_wr_ack, i_stall, d_stall} !== 58'h0) begin
      errors++; $display("FAIL reset_outputs: mem_en=%b mem_addr=%h fill_we=%b%b stall=%b%b want all 0",
                         mem_en, mem_addr, i_fill_we, d_fill_we, i_stall, d_stall);
    end
    i_miss = 1'b1; i_miss_addr = 16'h4444;
    nxt(); #1;
    checks++;
    if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_hold_idle: mem_en=%b want 0", mem_en); end
    checks++;
    if (i_stall !== 1'b1) begin errors++; $display("FAIL reset_istall: i_stall=%b want 1", i_stall); end
    i_miss = 1'b0;
    nxt();
    rst_n = 1'b1;
    repeat (2) nxt();
    #1;
    checks++;
    if ({mem_en, i_fill_we, d_fill_we, d_wr_ack} !== 4'b0) begin
      errors++; $display("FAIL idle_quiet: mem_en=%b we=%b%b ack=%b want 0", mem_en, i_fill_we, d_fill_we, d_wr_ack);
    end
    nxt();
  endtask

  task automatic test_i_fill();
    clear_obs();
    i_miss = 1'b1; i_miss_addr = 16'h1234;
    observe(15);
    checks++;
    if (rd_a.size() !== 8) begin errors++; $display("FAIL ifill_nreads: got %0d want 8", rd_a.size()); end
    checks++;
    if (rd_c[0] !== 1) begin errors++; $display("FAIL ifill_first_issue: cycle %0d want 1", rd_c[0]); end
    for (int k = 0; k < 8; k++) begin
      logic [15:0] a;
      a = 16'h1230 + 16'(2 * k);
      checks++;
      if (rd_a[k] !== a) begin errors++; $display("FAIL ifill_addr[%0d]: got %h want %h", k, rd_a[k], a); end
      checks++;
      if (ii_q[k] !== 3'(k) || ic_q[k] !== 5 + k) begin
        errors++; $display("FAIL ifill_idx[%0d]: idx %0d at cycle %0d want idx %0d at %0d", k, ii_q[k], ic_q[k], k, 5 + k);
      end
      checks++;
      if (id_q[k] !== (a ^ 16'h5A5A)) begin errors++; $display("FAIL ifill_data[%0d]: got %h want %h", k, id_q[k], a ^ 16'h5A5A); end
    end
    checks++;
    if (idone_q.size() !== 1 || idone_q[0] !== 12) begin
      errors++; $display("FAIL ifill_done: %0d pulses, first at %0d want 1 at 12", idone_q.size(), idone_q[0]);
    end
    checks++;
    if (istall_n !== 13) begin errors++; $display("FAIL ifill_stall: high %0d cycles want 13", istall_n); end
    checks++;
    if (dc_q.size() !== 0) begin errors++; $display("FAIL ifill_no_dwe: got %0d want 0", dc_q.size()); end
  endtask

  task automatic test_priority_d_over_i();
    clear_obs();
    i_miss = 1'b1; i_miss_addr = 16'h4450;
    d_miss = 1'b1; d_miss_addr = 16'h80A6;
    observe(28);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (rd_a[k] !== 16'h80A0 + 16'(2 * k)) begin
        errors++; $display("FAIL prio_daddr[%0d]: got %h want %h", k, rd_a[k], 16'h80A0 + 16'(2 * k));
      end
    end
    checks++;
    if (ddone_q.size() !== 1 || ddone_q[0] !== 12) begin
      errors++; $display("FAIL prio_ddone: %0d pulses, first at %0d want 1 at 12", ddone_q.size(), ddone_q[0]);
    end
    checks++;
    if (rd_c[8] !== 14 || rd_a[8] !== 16'h4450) begin
      errors++; $display("FAIL prio_istart: %h at cycle %0d want 4450 at 14", rd_a[8], rd_c[8]);
    end
    checks++;
    if (idone_q.size() !== 1 || idone_q[0] !== 25) begin
      errors++; $display("FAIL prio_idone: %0d pulses, first at %0d want 1 at 25", idone_q.size(), idone_q[0]);
    end
    checks++;
    if (istall_n !== 26) begin errors++; $display("FAIL prio_istall: high %0d cycles want 26", istall_n); end
  endtask

  task automatic test_write_first();
    clear_obs();
    i_miss = 1'b1; i_miss_addr = 16'h0200;
    d_miss = 1'b1; d_miss_addr = 16'h0300;
    d_wr_req = 1'b1; d_wr_addr = 16'h0010; d_wr_data = 16'hBEEF;
    observe(30);
    checks++;
    if (wr_c.size() !== 1 || wr_c[0] !== 1) begin
      errors++; $display("FAIL wr_issue: %0d writes, first at %0d want 1 at 1", wr_c.size(), wr_c[0]);
    end
    checks++;
    if (wr_a[0] !== 16'h0010 || wr_d[0] !== 16'hBEEF) begin
      errors++; $display("FAIL wr_payload: addr %h data %h want 0010 BEEF", wr_a[0], wr_d[0]);
    end
    checks++;
    if (ack_q.size() !== 1 || ack_q[0] !== 1) begin
      errors++; $display("FAIL wr_ack: %0d pulses, first at %0d want 1 at 1", ack_q.size(), ack_q[0]);
    end
    checks++;
    if (rd_c[0] !== 3 || rd_a[0] !== 16'h0300) begin
      errors++; $display("FAIL wr_then_d: %h at cycle %0d want 0300 at 3", rd_a[0], rd_c[0]);
    end
    checks++;
    if (ddone_q[0] !== 14) begin errors++; $display("FAIL wr_ddone: at %0d want 14", ddone_q[0]); end
    checks++;
    if (rd_c[8] !== 16 || rd_a[8] !== 16'h0200) begin
      errors++; $display("FAIL wr_then_i: %h at cycle %0d want 0200 at 16", rd_a[8], rd_c[8]);
    end
    checks++;
    if (idone_q[0] !== 27) begin errors++; $display("FAIL wr_idone: at %0d want 27", idone_q[0]); end
  endtask

  task automatic test_write_during_fill();
    clear_obs();
    i_miss = 1'b1; i_miss_addr = 16'h2000;
    observe(4);
    d_wr_req = 1'b1; d_wr_addr = 16'h0042; d_wr_data = 16'h1357;
    #1;
    checks++;
    if (d_stall !== 1'b1) begin errors++; $display("FAIL wdf_dstall_now: got %b want 1", d_stall); end
    observe(14);
    checks++;
    if (idone_q[0] !== 12) begin errors++; $display("FAIL wdf_idone: at %0d want 12", idone_q[0]); end
    checks++;
    if (wr_c.size() !== 1 || wr_c[0] !== 14) begin
      errors++; $display("FAIL wdf_write: %0d writes, first at %0d want 1 at 14", wr_c.size(), wr_c[0]);
    end
    checks++;
    if (ack_q.size() !== 1 || ack_q[0] !== 14 || wr_a[0] !== 16'h0042 || wr_d[0] !== 16'h1357) begin
      errors++; $display("FAIL wdf_ack: ack at %0d addr %h data %h want 14 0042 1357", ack_q[0], wr_a[0], wr_d[0]);
    end
    checks++;
    if (dstall_n !== 11) begin errors++; $display("FAIL wdf_dstall: high %0d cycles want 11", dstall_n); end
  endtask

  task automatic test_reset_mid_fill();
    clear_obs();
    d_miss = 1'b1; d_miss_addr = 16'h3300;
    observe(6);
    rst_n = 1'b0;
    observe(1);
    #1;
    checks++;
    if ({mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_idx, i_fill_we, d_fill_we,
         i_fill_done, d_fill_done, d_wr_ack} !== 56'h0) begin
      errors++; $display("FAIL rst_mid_outputs: mem_en=%b addr=%h fill_data=%h d_we=%b want all 0",
                         mem_en, mem_addr, fill_data, d_fill_we);
    end
    observe(4);
    rst_n = 1'b1;
    observe(15);
    checks++;
    if (dc_q.size() !== 10 || dc_q[1] !== 6) begin
      errors++; $display("FAIL rst_late_valid: %0d d writes, second at %0d want 10 with second at 6", dc_q.size(), dc_q[1]);
    end
    checks++;
    if (rd_a.size() !== 14 || rd_c[6] !== 12 || rd_a[6] !== 16'h3300) begin
      errors++; $display("FAIL rst_restart_issue: %0d reads, restart %h at %0d want 14, 3300 at 12", rd_a.size(), rd_a[6], rd_c[6]);
    end
    checks++;
    if (dc_q[2] !== 16 || di_q[2] !== 3'd0 || dd_q[2] !== (16'h3300 ^ 16'h5A5A)) begin
      errors++; $display("FAIL rst_restart_word0: idx %0d data %h at %0d want 0 %h at 16", di_q[2], dd_q[2], dc_q[2], 16'h3300 ^ 16'h5A5A);
    end
    checks++;
    if (ddone_q.size() !== 1 || ddone_q[0] !== 23) begin
      errors++; $display("FAIL rst_restart_done: %0d pulses, first at %0d want 1 at 23", ddone_q.size(), ddone_q[0]);
    end
  endtask

  task automatic test_back_to_back();
    clear_obs();
    i_miss = 1'b1; i_miss_addr = 16'h0000;
    observe(13);
    i_miss = 1'b1; i_miss_addr = 16'h0010;
    observe(16);
    checks++;
    if (idone_q.size() !== 2 || idone_q[0] !== 12 || idone_q[1] !== 25) begin
      errors++; $display("FAIL b2b_done: %0d pulses at %0d,%0d want 2 at 12,25", idone_q.size(), idone_q[0], idone_q[1]);
    end
    checks++;
    if (rd_c[8] !== 14 || rd_a[8] !== 16'h0010) begin
      errors++; $display("FAIL b2b_second_issue: %h at %0d want 0010 at 14", rd_a[8], rd_c[8]);
    end
    checks++;
    if (ic_q.size() !== 16 || ii_q[8] !== 3'd0 || ic_q[8] !== 18) begin
      errors++; $display("FAIL b2b_idx_restart: %0d writes, idx %0d at %0d want 16, 0 at 18", ic_q.size(), ii_q[8], ic_q[8]);
    end
    checks++;
    if (id_q[15] !== (16'h001E ^ 16'h5A5A)) begin
      errors++; $display("FAIL b2b_last_data: got %h want %h", id_q[15], 16'h001E ^ 16'h5A5A);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_i_fill();
    test_priority_d_over_i();
    test_write_first();
    test_write_during_fill();
    test_reset_mid_fill();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single-port, multi-cycle main memory shared by the instruction cache and the data cache of the 16-bit pipelined CPU.
- Arbitrates between an I-cache miss, a D-cache miss and write-through stores.
- Performs 8-word block fills and single-word writes.
- Drives the per-side stall signals that freeze the pipeline.

Parameters:
- ADDR_W, 16, byte address width.
- DATA_W, 16, memory word width.
- WORDS, 8, words per cache block (block = 16 bytes; word index = addr[3:1]).
- MEM_LAT, 4, cycles from read issue to mem_data_valid; memory is pipelined, one read issue per cycle.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- i_miss  in  1  I-cache miss request; level, held until i_fill_done.
- i_miss_addr  in  16  I-miss byte address.
- d_miss  in  1  D-cache miss request; level, held until d_fill_done.
- d_miss_addr  in  16  D-miss byte address.
- d_wr_req  in  1  store write-through request; level, held until d_wr_ack.
- d_wr_addr  in  16  store byte address.
- d_wr_data  in  16  store data.
- mem_en  out  1  memory access this cycle.
- mem_wr  out  1  1 = write, 0 = read (valid when mem_en).
- mem_addr  out  16  memory byte address.
- mem_wdata  out  16  write data.
- mem_rdata  in  16  read data.
- mem_data_valid  in  1  mem_rdata valid.
- fill_data  out  16  word to write into the cache being filled.
- fill_idx  out  3  word index within the block.
- i_fill_we  out  1  write fill_data into the I-cache block.
- d_fill_we  out  1  write fill_data into the D-cache block.
- i_fill_done  out  1  1-cycle pulse on the last I word.
- d_fill_done  out  1  1-cycle pulse on the last D word.
- d_wr_ack  out  1  1-cycle pulse when the store is issued.
- i_stall  out  1  freeze fetch.
- d_stall  out  1  freeze memory stage.

Behaviour:
- States: IDLE, WRITE, FILL_I, FILL_D.
- Reset (rst_n=0 at a rising edge):
  - state goes to IDLE; issue_cnt = recv_cnt = 0; captured block address = 0.
  - All registered outputs go to 0.
  - Applies mid-fill or mid-write too: the transaction is abandoned, and any mem_data_valid arriving afterwards while in IDLE is ignored.
- IDLE arbitration, evaluated each cycle with fixed priority d_wr_req > d_miss > i_miss:
  - d_wr_req: go to WRITE.
  - else d_miss: capture {d_miss_addr[15:4],4'h0} and go to FILL_D.
  - else i_miss: capture {i_miss_addr[15:4],4'h0} and go to FILL_I.
  - IDLE drives no memory traffic.
- WRITE (exactly 1 cycle):
  - Outputs: mem_en=1, mem_wr=1, mem_addr=d_wr_addr, mem_wdata=d_wr_data, d_wr_ack=1.
  - Next state is IDLE.
- FILL_x, issue side:
  - While issue_cnt<WORDS: mem_en=1, mem_wr=0, mem_addr={blk[15:4],issue_cnt[2:0],1'b0}, and issue_cnt increments each cycle.
  - Issues occur on the first WORDS cycles of the state.
- FILL_x, receive side:
  - On each mem_data_valid: fill_data=mem_rdata, fill_idx=recv_cnt, x_fill_we=1, and recv_cnt increments.
  - fill_data, fill_idx and x_fill_we are combinational from mem_rdata and mem_data_valid.
- Fill completion:
  - When recv_cnt==WORDS-1 and mem_data_valid, x_fill_done=1 in the same cycle.
  - Next state is IDLE; counters clear.
  - Last word arrives WORDS-1+MEM_LAT cycles after the first FILL cycle (11 with defaults).
- Stalls (combinational):
  - i_stall = i_miss.
  - d_stall = d_miss | d_wr_req.
  - Both drop once the requester deasserts after its done/ack.
- Requests arriving during a non-IDLE state are not serviced until the return to IDLE, and the corresponding stall is held throughout.
- A completed requester deasserts the cycle after its done/ack, so no duplicate service occurs.
- Minimum gap between transactions: one IDLE cycle.
- No write-while-fill: memory traffic is never overlapped between transactions.

Test Plan:
- i_miss=1, i_miss_addr=0x1234 from IDLE -> FILL_I:
  - mem_addr 0x1230,0x1232,…,0x123E on 8 consecutive cycles.
  - i_fill_we with fill_idx 0..7 starting 4 cycles after the first issue.
  - i_fill_done on the 12th FILL cycle; i_stall high throughout.
- i_miss and d_miss asserted in the same cycle (d_miss_addr=0x80A6) -> D fill first:
  - mem_addr 0x80A0..0x80AE; d_fill_done.
  - One IDLE cycle, then I fill; i_stall held high the whole time.
- d_wr_req (addr 0x0010, data 0xBEEF) with d_miss and i_miss pending -> WRITE first:
  - One cycle with mem_en=1, mem_wr=1, mem_addr=0x0010, mem_wdata=0xBEEF, d_wr_ack=1.
  - Then D fill, then I fill.
- d_wr_req raised during FILL_I:
  - d_stall=1 immediately; no write issued until after i_fill_done plus one IDLE cycle; then d_wr_ack pulses.
- rst_n=0 on the 6th FILL_D cycle:
  - Next cycle IDLE; all outputs 0.
  - Late mem_data_valid pulses produce no d_fill_we.
  - After rst_n=1 with d_miss still high, the fill restarts at word 0.
- Back-to-back I misses (0x0000 then 0x0010):
  - Second fill starts exactly one IDLE cycle after the first i_fill_done.
  - fill_idx restarts at 0.
